// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: decoder strobes to a req/ack data-memory port; done at least 2 cycles after start, mem_req held until mem_ack.
// Build option LSU_MISALIGN_TRAP_EN faults misaligned accesses instead of forcing natural alignment.
module lsu_mem_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            memread,
  input  logic            we,
  input  logic [2:0]      width,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e          state_q;
  logic            busy_q, done_q, err_q, flt_q;
  logic            mem_req_q, mem_we_q;
  logic [XLEN-1:0] rdata_q, mem_addr_q, mem_wdata_q;
  logic [3:0]      mem_be_q;
  logic [2:0]      width_q;
  logic [1:0]      lo_q;
  logic [CW-1:0]   cnt_q;

  logic            bad_width, fault;
  logic [1:0]      lo_d;
  logic [3:0]      be_d;
  logic [XLEN-1:0] wdata_d, ld_ext;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
`ifdef LSU_MISALIGN_TRAP_EN
  logic            misal;
`endif

  // Request decode: legality, effective lane offset, byte enables and lane-replicated store data.
  always_comb begin
    case (width)
      3'b000, 3'b001, 3'b010: bad_width = 1'b0;
      3'b100, 3'b101:         bad_width = we;
      default:                bad_width = 1'b1;
    endcase
    fault = (memread && we) || bad_width;
`ifdef LSU_MISALIGN_TRAP_EN
    misal = ((width[1:0] == 2'b01) && addr[0]) || ((width == 3'b010) && (addr[1:0] != 2'b00));
    fault = fault || misal;
`endif
    lo_d = addr[1:0];
    if (width[1:0] == 2'b01) lo_d[0] = 1'b0;
    if (width == 3'b010)     lo_d    = 2'b00;
    be_d    = 4'b1111;
    wdata_d = '0;
    if (we) begin
      wdata_d = wdata;
      case (width[1:0])
        2'b00: begin
          be_d    = 4'b0001 << lo_d;
          wdata_d = {4{wdata[7:0]}};
        end
        2'b01: begin
          be_d    = 4'b0011 << {lo_d[1], 1'b0};
          wdata_d = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lane_b = mem_rdata[{lo_q, 3'b000} +: 8];
    lane_h = mem_rdata[{lo_q[1], 4'b0000} +: 16];
    case (width_q)
      3'b000:  ld_ext = {{24{lane_b[7]}}, lane_b};
      3'b100:  ld_ext = {24'h000000, lane_b};
      3'b001:  ld_ext = {{16{lane_h[15]}}, lane_h};
      3'b101:  ld_ext = {16'h0000, lane_h};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      flt_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      width_q     <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && (memread || we)) begin
            busy_q  <= 1'b1;
            width_q <= width;
            lo_q    <= lo_d;
            cnt_q   <= '0;
            flt_q   <= fault;
            state_q <= ACCESS;
            // A faulting request spends its ACCESS cycle without touching memory.
            if (!fault) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= we;
              mem_addr_q  <= {addr[XLEN-1:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
            end
          end
        end
        ACCESS: begin
          if (flt_q) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= '0;
            state_q <= DONE;
          end else if (mem_ack) begin
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b0;
            rdata_q   <= mem_we_q ? '0 : ld_ext;
            state_q   <= DONE;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            rdata_q   <= '0;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a short timeout so the timeout path is reachable.
module tb_lsu_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, memread, we, mem_ack;
  logic [2:0]  width;
  logic [31:0] addr, wdata, mem_rdata;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .memread(memread), .we(we), .width(width),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    logic        rd, wr;
    logic [2:0]  w;
    logic [31:0] a, wd;
    int          wait_n;
    logic [31:0] mrd;
    logic        e_req, e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rdata;
    logic        e_err;
    int          e_lat, e_nreq;
  } vec_t;

  vec_t vecs[12];
  vec_t v_tmo, v_sw;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Issue one access and play the memory side: ack on request cycle wait_n+1.
  task automatic run(input vec_t v, input string tag);
    bit got = 1'b0;
    int lat = 0;
    int nreq = 0;
    @(negedge clk);
    start = 1'b1; memread = v.rd; we = v.wr; width = v.w; addr = v.a; wdata = v.wd;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      start   = 1'b0;
      mem_ack = 1'b0;
      if (done) begin
        got = 1'b1;
        lat = c;
      end else if (mem_req) begin
        nreq++;
        chk({tag, "_we"},   mem_we,   v.e_we);
        chk({tag, "_addr"}, mem_addr, v.e_addr);
        chk({tag, "_be"},   mem_be,   v.e_be);
        if (v.wr) chk({tag, "_wdata"}, mem_wdata, v.e_wd);
        if (nreq == v.wait_n + 1) begin
          mem_ack   = 1'b1;
          mem_rdata = v.mrd;
        end
      end
    end
    chk({tag, "_done_seen"}, got, 1'b1);
    chk({tag, "_latency"}, lat, v.e_lat);
    chk({tag, "_req_cycles"}, nreq, v.e_nreq);
    chk({tag, "_busy_at_done"}, busy, 1'b1);
    chk({tag, "_err"}, err, v.e_err);
    chk({tag, "_rdata"}, rdata, v.e_rdata);
  endtask

  initial begin
    //          rd wr width   addr        wdata         wait mem_rdata      req we  addr        be    wdata         rdata         err lat nreq
    vecs[0]  = '{1, 0, 3'b010, 32'h100, 32'h0,        0, 32'hDEADBEEF, 1, 0, 32'h100, 4'hF, 32'h0,        32'hDEADBEEF, 0, 2, 1};
    vecs[1]  = '{1, 0, 3'b000, 32'h203, 32'h0,        0, 32'h80123456, 1, 0, 32'h200, 4'hF, 32'h0,        32'hFFFFFF80, 0, 2, 1};
    vecs[2]  = '{1, 0, 3'b100, 32'h203, 32'h0,        0, 32'h80123456, 1, 0, 32'h200, 4'hF, 32'h0,        32'h00000080, 0, 2, 1};
    vecs[3]  = '{0, 1, 3'b001, 32'h012, 32'h0000ABCD, 3, 32'h0,        1, 1, 32'h010, 4'hC, 32'hABCDABCD, 32'h0,        0, 5, 4};
    vecs[4]  = '{0, 1, 3'b000, 32'h041, 32'h123456A5, 1, 32'h0,        1, 1, 32'h040, 4'h2, 32'hA5A5A5A5, 32'h0,        0, 3, 2};
    vecs[5]  = '{1, 0, 3'b001, 32'h102, 32'h0,        0, 32'h80017FFF, 1, 0, 32'h100, 4'hF, 32'h0,        32'hFFFF8001, 0, 2, 1};
    vecs[6]  = '{1, 0, 3'b101, 32'h102, 32'h0,        0, 32'h80017FFF, 1, 0, 32'h100, 4'hF, 32'h0,        32'h00008001, 0, 2, 1};
    vecs[7]  = '{1, 1, 3'b010, 32'h100, 32'h0,        0, 32'h0,        0, 0, 32'h0,   4'h0, 32'h0,        32'h0,        1, 2, 0};
    vecs[8]  = '{1, 0, 3'b011, 32'h100, 32'h0,        0, 32'h0,        0, 0, 32'h0,   4'h0, 32'h0,        32'h0,        1, 2, 0};
    vecs[9]  = '{0, 1, 3'b100, 32'h100, 32'h0,        0, 32'h0,        0, 0, 32'h0,   4'h0, 32'h0,        32'h0,        1, 2, 0};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[10] = '{1, 0, 3'b001, 32'h101, 32'h0,        0, 32'h12348765, 0, 0, 32'h0,   4'h0, 32'h0,        32'h0,        1, 2, 0};
    vecs[11] = '{0, 1, 3'b010, 32'h043, 32'hCAFEF00D, 0, 32'h0,        0, 0, 32'h0,   4'h0, 32'h0,        32'h0,        1, 2, 0};
`else
    vecs[10] = '{1, 0, 3'b001, 32'h101, 32'h0,        0, 32'h12348765, 1, 0, 32'h100, 4'hF, 32'h0,        32'hFFFF8765, 0, 2, 1};
    vecs[11] = '{0, 1, 3'b010, 32'h043, 32'hCAFEF00D, 0, 32'h0,        1, 1, 32'h040, 4'hF, 32'hCAFEF00D, 32'h0,        0, 2, 1};
`endif
    v_tmo = '{1, 0, 3'b010, 32'h080, 32'h0,        100, 32'h0,      1, 0, 32'h080, 4'hF, 32'h0,        32'h0,        1, 5, 4};
    v_sw  = '{0, 1, 3'b010, 32'h040, 32'h11223344, 0, 32'h0,        1, 1, 32'h040, 4'hF, 32'h11223344, 32'h0,        0, 2, 1};

    rst = 1'b1; start = 1'b0; memread = 1'b0; we = 1'b0; width = 3'b000;
    addr = '0; wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", mem_be, 4'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run(vecs[i], $sformatf("v%0d", i));

    // Timeout, then an ack arriving in IDLE must be ignored.
    run(v_tmo, "timeout");
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_done", done, 1'b0);
    chk("late_ack_busy", busy, 1'b0);
    @(negedge clk);
    chk("late_ack_done2", done, 1'b0);
    chk("late_ack_err_hold", err, 1'b1);
    chk("late_ack_rdata_hold", rdata, 32'h0);

    // Start with neither strobe is not accepted.
    start = 1'b1; memread = 1'b0; we = 1'b0; width = 3'b010; addr = 32'h100;
    @(negedge clk);
    start = 1'b0;
    chk("nop_busy", busy, 1'b0);
    chk("nop_req", mem_req, 1'b0);
    @(negedge clk);
    chk("nop_done", done, 1'b0);

    // Start while busy is ignored.
    start = 1'b1; memread = 1'b1; we = 1'b0; width = 3'b010; addr = 32'h500;
    @(negedge clk);
    memread = 1'b0; we = 1'b1; addr = 32'h600; wdata = 32'h77777777;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_addr", mem_addr, 32'h500);
    chk("busy_start_we", mem_we, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("busy_start_done", done, 1'b1);
    chk("busy_start_rdata", rdata, 32'h5A5A5A5A);
    @(negedge clk);
    @(negedge clk);
    chk("busy_start_no_relaunch", mem_req, 1'b0);
    chk("busy_start_idle", busy, 1'b0);

    // Reset in the middle of an access drops the request at once.
    start = 1'b1; memread = 1'b1; we = 1'b0; width = 3'b010; addr = 32'h300;
    @(negedge clk);
    start = 1'b0;
    chk("midrst_req_before", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_req_async", mem_req, 1'b0);
    chk("midrst_busy_async", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("midrst_no_done%0d", c), done, 1'b0);
    end
    run(v_sw, "post_rst_sw");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
